// File: rtl/ic_controller.sv
// ---------------------------------------------------------------------------
// ic_controller -- direct-mapped instruction cache controller.
//
// A fetch PC is looked up combinationally. On a miss the controller latches
// the line address, raises a refill request, then absorbs WORDS_PER_LINE
// data beats in ascending word order before marking the line valid. Refills
// always run to completion; fetch redirects during a refill are picked up
// again when the controller returns to idle.
//
// Optional feature macro: IC_PERF_CNT_EN adds miss_count_o, a wrapping
// 32-bit count of refills started.
//
// Ports:
//   clk_i, reset_n_i        clock, async active-low reset
//   pc_f_i                  fetch PC (word aligned)
//   instr_f_o/instr_hit_f_o instruction word and hit flag for pc_f_i
//   ic_repl_permit_o        controller idle
//   mem_req_o/mem_addr_o    refill request + line-aligned address
//   mem_ready_i             request accepted
//   mem_rvalid_i/mem_rdata_i refill beat
//   miss_count_o            refill counter (IC_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module ic_controller #(
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] pc_f_i,
  output logic [31:0] instr_f_o,
  output logic        instr_hit_f_o,
  output logic        ic_repl_permit_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
`ifdef IC_PERF_CNT_EN
  ,
  output logic [31:0] miss_count_o
`endif
);

  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - 2 - OW - IW;
  localparam logic [OW-1:0] LAST_BEAT = OW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

  state_t              r_state, w_next;
  logic [SETS-1:0]     r_valid;
  logic [TW-1:0]       r_tag  [SETS];
  logic [31:0]         r_data [SETS][WORDS_PER_LINE];
  logic [31:0]         r_line_addr;
  logic [OW-1:0]       r_beat;

  logic [OW-1:0]       w_off;
  logic [IW-1:0]       w_idx;
  logic [TW-1:0]       w_tag;
  logic [IW-1:0]       w_lidx;
  logic [TW-1:0]       w_ltag;
  logic                w_hit;
  logic                w_miss;
  logic                w_fill;
  logic                w_last;
  logic                w_unused_pc;

  assign w_off  = pc_f_i[OW+1:2];
  assign w_idx  = pc_f_i[OW+IW+1:OW+2];
  assign w_tag  = pc_f_i[31:OW+IW+2];
  assign w_lidx = r_line_addr[OW+IW+1:OW+2];
  assign w_ltag = r_line_addr[31:OW+IW+2];
  assign w_unused_pc = &{1'b0, pc_f_i[1:0]};

  assign w_hit  = (r_state == S_IDLE) & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss = (r_state == S_IDLE) & ~w_hit;
  assign w_fill = (r_state == S_FILL) & mem_rvalid_i;
  assign w_last = w_fill & (r_beat == LAST_BEAT);

  assign instr_hit_f_o    = w_hit;
  assign instr_f_o        = r_data[w_idx][w_off];
  assign ic_repl_permit_o = (r_state == S_IDLE);
  assign mem_addr_o       = r_line_addr;

  always_comb begin
    w_next    = r_state;
    mem_req_o = 1'b0;
    case (r_state)
      S_IDLE: if (w_miss) w_next = S_REQ;
      S_REQ: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) w_next = S_FILL;
      end
      S_FILL: if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_beat      <= '0;
      r_line_addr <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss)
        r_line_addr <= {pc_f_i[31:OW+2], {(OW+2){1'b0}}};
      if ((r_state == S_REQ) && mem_ready_i)
        r_beat <= '0;
      else if (w_fill)
        r_beat <= r_beat + 1'b1;  // power-of-2 line: last beat wraps to 0
      if (w_last)
        r_valid[w_lidx] <= 1'b1;
    end
  end

  // Line storage needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk_i) begin
    if (w_fill)
      r_data[w_lidx][r_beat] <= mem_rdata_i;
    if (w_last)
      r_tag[w_lidx] <= w_ltag;
  end

`ifdef IC_PERF_CNT_EN
  logic [31:0] r_miss_cnt;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  r_miss_cnt <= '0;
    else if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
  end
  assign miss_count_o = r_miss_cnt;
`endif

endmodule

// File: doc/ic_controller.md
IC_CONTROLLER -- requirements
Module: ic_controller

Interface
REQ-001 Parameter SETS, default 64, number of direct-mapped lines (power of 2).
REQ-002 Parameter WORDS_PER_LINE, default 4, 32-bit words per line (power of 2, >=2).
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n_i  in  1  asynchronous, active-low reset.
REQ-005 pc_f_i  in  32  fetch-stage PC, word aligned.
REQ-006 instr_f_o  out  32  instruction word for pc_f_i; valid when instr_hit_f_o=1.
REQ-007 instr_hit_f_o  out  1  fetch hit; 0 stalls all pipeline stages.
REQ-008 ic_repl_permit_o  out  1  controller idle; a redirect-driven line replacement may proceed.
REQ-009 mem_req_o  out  1  line refill request to memory.
REQ-010 mem_addr_o  out  32  line-aligned refill address.
REQ-011 mem_ready_i  in  1  memory accepts request (handshake when mem_req_o & mem_ready_i).
REQ-012 mem_rvalid_i  in  1  refill data beat valid.
REQ-013 mem_rdata_i  in  32  refill data beat, ascending word order.
REQ-014 miss_count_o  out  32  refill counter (present only with IC_PERF_CNT_EN).

Function
REQ-015 Address split: offset = pc[log2(WORDS_PER_LINE)+1:2], index = next log2(SETS) bits, tag = remaining upper bits.
REQ-016 Per line: valid bit, tag register, WORDS_PER_LINE data words.
REQ-017 FSM states: IDLE, REQ, FILL.
REQ-018 instr_hit_f_o = (state==IDLE) & valid[index] & (tag[index]==pc tag), combinational from pc_f_i.
REQ-019 instr_f_o = data[index][offset], combinational; value is don't-care when instr_hit_f_o=0.
REQ-020 IDLE with instr_hit_f_o=0: latch line address {pc[31:offset_msb+1], zeros}, go to REQ on next edge.
REQ-021 REQ: mem_req_o=1, mem_addr_o=latched line address held stable; on mem_req_o & mem_ready_i go to FILL, clear beat counter.
REQ-022 FILL: mem_req_o=0; each mem_rvalid_i beat writes mem_rdata_i to data[latched index][beat counter] and increments counter.
REQ-023 On the final beat (counter==WORDS_PER_LINE-1), set valid and tag for the latched index, clear counter (wrap to 0), return to IDLE.
REQ-024 mem_rvalid_i outside FILL is ignored; no array write occurs.
REQ-025 ic_repl_permit_o = (state==IDLE).
REQ-026 A refill already requested always completes; pc_f_i changes (branch redirect) during REQ/FILL do not abort it.
REQ-027 On return to IDLE, hit is re-evaluated against the current pc_f_i; a different missing line starts a new refill.
REQ-028 Minimum miss penalty: 1 cycle detect + 1 cycle REQ (ready=1) + WORDS_PER_LINE beats; hit visible the cycle after the last beat.
REQ-029 Refill of a line overwrites any prior valid line at that index (direct-mapped replacement).

Reset
REQ-030 reset_n_i=0 immediately forces state=IDLE, all valid bits=0, beat counter=0, mem_req_o=0, miss_count_o=0.
REQ-031 Reset during REQ/FILL aborts the refill; the target line stays invalid; data array contents need not be cleared.
REQ-032 After reset, instr_hit_f_o=0 and ic_repl_permit_o=1.

Configuration
REQ-033 Macro IC_PERF_CNT_EN defined: miss_count_o exists and increments by 1 on each IDLE->REQ transition, wrapping at 2^32.
REQ-034 Macro undefined: miss_count_o port and counter logic are absent; all other behaviour identical.

Verification
REQ-035 Cold miss: reset, pc_f_i=0x100, ready=1, beats 0xA0..0xA3 -> mem_addr_o=0x100, hit=1 with instr_f_o=0xA0 the cycle after beat 4.
REQ-036 Line reuse: after REQ-035, pc_f_i=0x10C -> hit=1 at once, instr_f_o=0xA3, mem_req_o stays 0.
REQ-037 Conflict: pc_f_i=0x100 + SETS*16 (0x500) -> miss, refill at 0x500; then pc_f_i=0x100 misses again.
REQ-038 Backpressure: mem_ready_i=0 for 5 cycles -> mem_req_o and mem_addr_o held stable, ic_repl_permit_o=0 throughout.
REQ-039 Redirect mid-FILL: pc_f_i 0x200->0x300 after beat 2 -> 0x200 line completes valid, then new refill at 0x300.
REQ-040 Reset after beat 2 of refill at 0x100 -> state IDLE, mem_req_o=0, pc_f_i=0x100 misses; with IC_PERF_CNT_EN, miss_count_o=0.
